// File: rtl/adder_share_arb.sv
// Round-robin time-sharing controller for one registered adder shared by NUM_REQ requesters.
// Optional ADDER_ARB_STATS_EN adds a saturating 16-bit accept counter on grant_cnt_o.
//
// state  | meaning
// S_IDLE | searching for a valid requester from rr_ptr; req_ready asserted combinationally
// S_WAIT | operands held on add_a/add_b while the shared adder result settles
// S_RESP | one-cycle rsp_valid strobe to the granted requester
module adder_share_arb #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int ADD_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W:0]           rsp_sum_o,
   output logic [DATA_W-1:0]         add_a_o,
   output logic [DATA_W-1:0]         add_b_o,
   input  logic [DATA_W:0]           add_sum_i
`ifdef ADDER_ARB_STATS_EN
   ,output logic [15:0]              grant_cnt_o
`endif
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]     gnt_q, gnt_d;
   logic [DATA_W-1:0]    add_a_q, add_a_d;
   logic [DATA_W-1:0]    add_b_q, add_b_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [DATA_W:0]      rsp_sum_q, rsp_sum_d;

   logic                 found;
   logic [PTR_W-1:0]     gnt;
   logic                 accept;

   // Wrap-around priority search starting at the round-robin pointer
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid_i[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
            found = 1'b1;
            gnt   = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         end
      end
   end

   assign accept      = (state_q == S_IDLE) && found;
   assign req_ready_o = accept ? (NUM_REQ'(1) << gnt) : '0;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = gnt_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      cnt_d       = cnt_q;
      rsp_valid_d = '0;
      rsp_sum_d   = rsp_sum_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               add_a_d  = req_a_i[int'(gnt)*DATA_W +: DATA_W];
               add_b_d  = req_b_i[int'(gnt)*DATA_W +: DATA_W];
               gnt_d    = gnt;
               rr_ptr_d = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
               cnt_d    = CNT_W'(ADD_LAT);
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            // ADD_LAT+1 cycles in WAIT: counter runs ADD_LAT down to 0
            if (cnt_q == '0) begin
               rsp_sum_d   = add_sum_i;
               rsp_valid_d = NUM_REQ'(1) << gnt_q;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         gnt_q       <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_sum_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_sum_q   <= rsp_sum_d;
      end
   end

   assign add_a_o     = add_a_q;
   assign add_b_o     = add_b_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_sum_o   = rsp_sum_q;

`ifdef ADDER_ARB_STATS_EN
   logic [15:0] grant_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt_q <= '0;
      end else if (accept && grant_cnt_q != 16'hFFFF) begin
         grant_cnt_q <= grant_cnt_q + 16'd1;
      end
   end

   assign grant_cnt_o = grant_cnt_q;
`else
   // Without statistics, accept only steers the FSM.
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: cycle-timeline reference model plus vector table and directed sequences.
// Define ADDER_ARB_STATS_EN to also exercise grant_cnt_o.
module tb_adder_share_arb;
   localparam int N   = 4;
   localparam int W   = 8;
   localparam int LAT = 1;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_a, req_b;
   logic [N-1:0]   req_ready, rsp_valid;
   logic [W:0]     rsp_sum, add_sum;
   logic [W-1:0]   add_a, add_b;
`ifdef ADDER_ARB_STATS_EN
   logic [15:0]    grant_cnt;
`endif

   adder_share_arb #(.NUM_REQ(N), .DATA_W(W), .ADD_LAT(LAT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .rsp_valid_o (rsp_valid),
      .rsp_sum_o   (rsp_sum),
      .add_a_o     (add_a),
      .add_b_o     (add_b),
      .add_sum_i   (add_sum)
`ifdef ADDER_ARB_STATS_EN
      ,.grant_cnt_o(grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Shared adder: LAT register stages
   logic [W:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign add_sum = pipe[LAT-1];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: timeline of when the adder is free and when a response is due
   int           m_ptr, m_free, m_rsp_cyc;
   logic [N-1:0] m_rsp_vec;
   logic [W:0]   m_rsp_sum;
   logic [N-1:0] last_acc;
   int           acc_cyc [$];
   logic [N-1:0] acc_vec [$];
   bit           auto_drop = 1'b1;

   initial begin : model
      logic [N-1:0] exp_ready;
      int g;
      m_ptr = 0; m_free = 0; m_rsp_cyc = -1; last_acc = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_ptr = 0; m_free = 0; m_rsp_cyc = -1; last_acc = '0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_sum", rsp_sum, 0);
            chk("rst_add_a", add_a, 0);
            chk("rst_add_b", add_b, 0);
         end else begin
            exp_ready = '0;
            g = 0;
            if (cyc >= m_free)
               for (int k = 0; k < N; k++)
                  if (exp_ready == '0 && req_valid[(m_ptr + k) % N]) begin
                     g = (m_ptr + k) % N;
                     exp_ready[g] = 1'b1;
                  end
            chk("req_ready", req_ready, exp_ready);
            if (cyc == m_rsp_cyc) begin
               chk("rsp_valid", rsp_valid, m_rsp_vec);
               chk("rsp_sum", rsp_sum, m_rsp_sum);
            end else begin
               chk("rsp_valid_idle", rsp_valid, 0);
            end
            last_acc = req_ready & req_valid;
            if (last_acc != '0) begin
               acc_cyc.push_back(cyc);
               acc_vec.push_back(last_acc);
            end
            if (exp_ready != '0) begin
               m_rsp_cyc = cyc + LAT + 2;
               m_free    = cyc + LAT + 3;
               m_rsp_vec = exp_ready;
               m_rsp_sum = (W+1)'(req_a[g*W +: W]) + (W+1)'(req_b[g*W +: W]);
               m_ptr     = (g + 1) % N;
            end
         end
      end
   end

   // Requesters drop valid the cycle after being accepted
   initial forever begin
      @(posedge clk); #1;
      if (auto_drop) req_valid = req_valid & ~last_acc;
   end

   task automatic cycle();
      @(posedge clk); #2;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_valid[i]    = 1'b1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      cycle(); cycle();
      rst = 1'b0;
   endtask

   task automatic wait_rsp(output logic [N-1:0] v, output logic [W:0] s);
      v = '0; s = '0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (rsp_valid != '0) begin
            v = rsp_valid; s = rsp_sum;
            return;
         end
      end
   endtask

   typedef struct {
      int         req;
      logic [W-1:0] a, b;
      logic [W:0] sum;
   } vec_t;

   vec_t tbl [6];

   initial begin : timeout
      #1000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [N-1:0] v;
      logic [W:0]   s;
      tbl[0] = '{0, 8'd255, 8'd255, 9'h1FE};
      tbl[1] = '{1, 8'd0,   8'd0,   9'h000};
      tbl[2] = '{2, 8'd255, 8'd1,   9'h100};
      tbl[3] = '{3, 8'd128, 8'd128, 9'h100};
      tbl[4] = '{1, 8'd100, 8'd27,  9'h07F};
      tbl[5] = '{2, 8'd1,   8'd254, 9'h0FF};

      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
      repeat (3) cycle();
      rst = 1'b0;

      // Single request latency
      set_req(0, 8'd3, 8'd4);
      @(negedge clk); chk("t1_ready", req_ready, 4'b0001);
      repeat (3) cycle();
      @(negedge clk);
      chk("t1_rsp_valid", rsp_valid, 4'b0001);
      chk("t1_rsp_sum", rsp_sum, 7);
      cycle();

      // All four held valid from reset: round-robin 0,1,2,3,0 every 4 cycles
      pulse_reset();
      acc_cyc.delete(); acc_vec.delete();
      auto_drop = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, W'(10 * i + 1), W'(200 + i));
      repeat (18) cycle();
      req_valid = '0;
      auto_drop = 1'b1;
      chk("t2_accept_count", acc_vec.size(), 5);
      for (int k = 0; k < 5 && k < acc_vec.size(); k++) begin
         chk("t2_grant_order", acc_vec[k], 4'b0001 << (k % N));
         chk("t2_grant_spacing", acc_cyc[k] - acc_cyc[0], 4 * k);
      end
      repeat (5) cycle();

      // Vector table, including full-scale operands
      for (int t = 0; t < 6; t++) begin
         set_req(tbl[t].req, tbl[t].a, tbl[t].b);
         wait_rsp(v, s);
         chk("tbl_rsp_valid", v, 4'b0001 << tbl[t].req);
         chk("tbl_rsp_sum", s, tbl[t].sum);
         cycle();
      end

      // Reset during WAIT discards the operation and restarts the pointer at 0
      pulse_reset();
      set_req(0, 8'd9, 8'd10);
      cycle();
      rst = 1'b1; #1;
      chk("t4_rsp_valid", rsp_valid, 0);
      chk("t4_add_a", add_a, 0);
      chk("t4_add_b", add_b, 0);
      chk("t4_rsp_sum", rsp_sum, 0);
      cycle(); cycle();
      rst = 1'b0;
      set_req(0, 8'd5, 8'd6);
      set_req(2, 8'd7, 8'd8);
      @(negedge clk); chk("t4_regrant", req_ready, 4'b0001);
      repeat (10) cycle();

      // Request arriving during WAIT waits for the first IDLE cycle
      acc_cyc.delete(); acc_vec.delete();
      set_req(1, 8'd33, 8'd44);
      cycle();
      set_req(2, 8'd50, 8'd60);
      @(negedge clk); chk("t5_ready_wait", req_ready, 0);
      cycle();
      @(negedge clk); chk("t5_add_a_hold", add_a, 33);
      repeat (4) cycle();
      chk("t5_accept_count", acc_vec.size(), 2);
      if (acc_vec.size() >= 2) begin
         chk("t5_second_grant", acc_vec[1], 4'b0100);
         chk("t5_second_time", acc_cyc[1] - acc_cyc[0], LAT + 3);
      end
      repeat (5) cycle();

`ifdef ADDER_ARB_STATS_EN
      pulse_reset();
      for (int k = 0; k < 5; k++) begin
         set_req(k % N, W'(k), W'(k));
         wait_rsp(v, s);
         cycle();
      end
      chk("t6_grant_cnt", grant_cnt, 5);
      rst = 1'b1; #1;
      chk("t6_grant_cnt_rst", grant_cnt, 0);
      cycle();
      rst = 1'b0;
`endif

      // Randomized traffic checked by the timeline model
      for (int c = 0; c < 400; c++) begin
         cycle();
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(2) == 0)
               set_req(i, W'($urandom), W'($urandom));
      end
      req_valid = '0;
      repeat (6) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
